// File: rtl/snake_pkg.sv
// Shared heading type and helpers for the snake direction path.
// Used by direction_arbiter and its button conditioning.
package snake_pkg;

   typedef enum logic [1:0] {
      UP    = 2'b00,
      DOWN  = 2'b01,
      LEFT  = 2'b10,
      RIGHT = 2'b11
   } dir_t;

   localparam dir_t DIR_RESET = RIGHT;

   // Two headings are opposite when they share an axis bit and differ in sign.
   function automatic logic dir_opposite(input dir_t a, input dir_t b);
      return (a[1] == b[1]) && (a[0] != b[0]);
   endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer, debounce counter and press (rising) pulse.
// A level is accepted after DEBOUNCE_CYCLES stable differing samples.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic press
);

   localparam int CNTW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic            s1;
   logic            s2;
   logic            level;
   logic [CNTW-1:0] cnt;

   // Bring the asynchronous button into the clock domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   // Count consecutive disagreeing samples; toggle the level on the last one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level <= 1'b0;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         press <= 1'b0;
         if (s2 != level) begin
            if (cnt == CNTW'(DEBOUNCE_CYCLES - 1)) begin
               level <= ~level;
               cnt   <= '0;
               press <= ~level;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/direction_arbiter.sv
// Debounces four buttons and queues legal turns, one released per step.
// Optional SNAKE_DIR_DROP_COUNT_EN adds a saturating o_drop_count output.
module direction_arbiter
   import snake_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int QUEUE_DEPTH     = 2
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             i_up,
   input  logic                             i_down,
   input  logic                             i_left,
   input  logic                             i_right,
   input  logic                             i_step,
   input  logic                             i_restart,
   output logic [1:0]                       o_dir,
   output logic [$clog2(QUEUE_DEPTH+1)-1:0] o_pending,
   output logic                             o_drop
`ifdef SNAKE_DIR_DROP_COUNT_EN
   ,
   output logic [7:0]                       o_drop_count
`endif
);

   localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int CW = $clog2(QUEUE_DEPTH + 1);

   logic [3:0]    raw;
   logic [3:0]    press;
   logic          any;
   dir_t          cand;
   dir_t          ref_dir;
   dir_t          dir;
   dir_t          q [QUEUE_DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [PW-1:0] last;
   logic [CW-1:0] count;
   logic          full;
   logic          legal;
   logic          do_pop;
   logic          do_push;
   logic          do_drop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign raw = {i_right, i_left, i_down, i_up};

   for (genvar g = 0; g < 4; g++) begin : g_btn
      button_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_btn (
         .clk  (clk),
         .rst_n(rst_n),
         .raw  (raw[g]),
         .press(press[g])
      );
   end

   // Fixed priority among same-cycle presses: UP > DOWN > LEFT > RIGHT.
   always_comb begin
      cand = UP;
      any  = |press;
      priority case (1'b1)
         press[0]: cand = UP;
         press[1]: cand = DOWN;
         press[2]: cand = LEFT;
         press[3]: cand = RIGHT;
         default:  cand = UP;
      endcase
   end

   // Check the winner against the newest queued turn, or the live heading.
   always_comb begin
      last    = (tail == '0) ? PW'(QUEUE_DEPTH - 1) : tail - 1'b1;
      ref_dir = (count != '0) ? q[last] : dir;
      full    = (count == CW'(QUEUE_DEPTH));
      legal   = any && (cand != ref_dir) && !dir_opposite(cand, ref_dir);
      do_pop  = i_step && (count != '0) && !i_restart;
      do_push = legal && (!full || do_pop) && !i_restart;
      do_drop = legal && full && !do_pop && !i_restart;
   end

   // Circular turn queue and current heading.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dir    <= DIR_RESET;
         head   <= '0;
         tail   <= '0;
         count  <= '0;
         o_drop <= 1'b0;
         for (int i = 0; i < QUEUE_DEPTH; i++) q[i] <= DIR_RESET;
      end else if (i_restart) begin
         dir    <= DIR_RESET;
         head   <= '0;
         tail   <= '0;
         count  <= '0;
         o_drop <= 1'b0;
      end else begin
         o_drop <= do_drop;
         if (do_pop) begin
            dir  <= q[head];
            head <= nxt(head);
         end
         if (do_push) begin
            q[tail] <= cand;
            tail    <= nxt(tail);
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   assign o_dir     = dir;
   assign o_pending = count;

`ifdef SNAKE_DIR_DROP_COUNT_EN
   // Saturating count of discarded legal presses; survives restart.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_drop_count <= '0;
      end else if (do_drop && (o_drop_count != 8'hFF)) begin
         o_drop_count <= o_drop_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_direction_arbiter.sv
// Scoreboard bench for direction_arbiter: expected output changes are
// queued by the stimulus and compared by a monitor on each change.
module tb_direction_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_up = 1'b0;
   logic       i_down = 1'b0;
   logic       i_left = 1'b0;
   logic       i_right = 1'b0;
   logic       i_step = 1'b0;
   logic       i_restart = 1'b0;
   logic [1:0] o_dir;
   logic [1:0] o_pending;
   logic       o_drop;
`ifdef SNAKE_DIR_DROP_COUNT_EN
   logic [7:0] o_drop_count;
`endif

   localparam logic [1:0] U = 2'b00;
   localparam logic [1:0] D = 2'b01;
   localparam logic [1:0] L = 2'b10;
   localparam logic [1:0] R = 2'b11;

   typedef struct {
      logic [1:0] dir;
      logic [1:0] pend;
      logic       drop;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   direction_arbiter dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_up     (i_up),
      .i_down   (i_down),
      .i_left   (i_left),
      .i_right  (i_right),
      .i_step   (i_step),
      .i_restart(i_restart),
      .o_dir    (o_dir),
      .o_pending(o_pending),
      .o_drop   (o_drop)
`ifdef SNAKE_DIR_DROP_COUNT_EN
      ,
      .o_drop_count(o_drop_count)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every change of the output tuple consumes one expectation.
   logic [4:0] prev;
   bit         first = 1'b1;
   always @(negedge clk) begin
      logic [4:0] cur;
      exp_t       e;
      cur = {o_dir, o_pending, o_drop};
      if (first || cur != prev) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_change cyc=%0d got dir=%b pend=%0d drop=%b",
                     cyc, o_dir, o_pending, o_drop);
         end else begin
            e = exp_q.pop_front();
            if (o_dir !== e.dir || o_pending !== e.pend || o_drop !== e.drop ||
                (e.cyc >= 0 && cyc != e.cyc)) begin
               failures++;
               $display("FAIL event cyc=%0d got dir=%b pend=%0d drop=%b want dir=%b pend=%0d drop=%b cyc=%0d",
                        cyc, o_dir, o_pending, o_drop, e.dir, e.pend, e.drop, e.cyc);
            end
         end
      end
      first = 1'b0;
      prev  = cur;
   end

   task automatic expect_ev(input logic [1:0] d, input logic [1:0] p,
                            input logic dr, input int c);
      exp_t e;
      e.dir = d; e.pend = p; e.drop = dr; e.cyc = c;
      exp_q.push_back(e);
   endtask

   task automatic set_btn(input logic [3:0] b);
      i_up = b[0]; i_down = b[1]; i_left = b[2]; i_right = b[3];
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Hold a button set long enough to debounce, then release it.
   task automatic press(input logic [3:0] b);
      @(negedge clk);
      set_btn(b);
      idle(10);
      set_btn(4'b0000);
      idle(10);
   endtask

   // Press with step and/or restart high on the edge that takes the press.
   task automatic press_ctl(input logic [3:0] b, input logic st, input logic rs);
      @(negedge clk);
      set_btn(b);
      idle(6);
      i_step = st;
      i_restart = rs;
      @(negedge clk);
      i_step = 1'b0;
      i_restart = 1'b0;
      idle(4);
      set_btn(4'b0000);
      idle(10);
   endtask

   task automatic step();
      @(negedge clk);
      i_step = 1'b1;
      @(negedge clk);
      i_step = 1'b0;
      idle(2);
   endtask

   task automatic restart();
      @(negedge clk);
      i_restart = 1'b1;
      @(negedge clk);
      i_restart = 1'b0;
      idle(2);
   endtask

   initial begin
      int n;
      // Reset state, then idle with no change.
      expect_ev(R, 0, 0, -1);
      idle(3);
      rst_n = 1'b1;
      idle(20);

      // Press latency: pending rises exactly 7 edges after the input.
      expect_ev(R, 1, 0, -1);
      @(negedge clk);
      n = cyc;
      exp_q[exp_q.size()-1].cyc = n + 7;
      i_up = 1'b1;
      idle(10);
      i_up = 1'b0;
      idle(10);
      expect_ev(U, 0, 0, -1);
      step();
      expect_ev(R, 0, 0, -1);
      restart();

      // Glitch of 3 cycles ignored, a held press accepted.
      @(negedge clk);
      i_down = 1'b1;
      idle(3);
      i_down = 1'b0;
      idle(15);
      expect_ev(R, 1, 0, -1);
      press(4'b0010);
      expect_ev(D, 0, 0, -1);
      step();
      expect_ev(R, 0, 0, -1);
      restart();

      // Null and reverse turns rejected; two legal turns queued.
      press(4'b0100);
      press(4'b1000);
      expect_ev(R, 1, 0, -1);
      press(4'b0001);
      expect_ev(R, 2, 0, -1);
      press(4'b0100);

      // Full queue drops; with a same-cycle step it is accepted.
      expect_ev(R, 2, 1, -1);
      expect_ev(R, 2, 0, -1);
      press(4'b0010);
      expect_ev(U, 2, 0, -1);
      press_ctl(4'b0010, 1'b1, 1'b0);
      expect_ev(L, 1, 0, -1);
      step();
      expect_ev(D, 0, 0, -1);
      step();

      // Simultaneous UP and LEFT: only UP queued.
      expect_ev(R, 0, 0, -1);
      restart();
      expect_ev(R, 1, 0, -1);
      press(4'b0101);
      expect_ev(U, 0, 0, -1);
      step();
      step();

      // Restart wins over same-cycle step and press on a full queue.
      expect_ev(U, 1, 0, -1);
      press(4'b0100);
      expect_ev(U, 2, 0, -1);
      press(4'b0010);
      expect_ev(R, 0, 0, -1);
      press_ctl(4'b0100, 1'b1, 1'b1);

`ifdef SNAKE_DIR_DROP_COUNT_EN
      checks++;
      if (o_drop_count !== 8'd1) begin
         failures++;
         $display("FAIL drop_count got %0d want 1", o_drop_count);
      end
`endif

      // Asynchronous reset mid-operation.
      expect_ev(R, 1, 0, -1);
      press(4'b0001);
      expect_ev(R, 0, 0, -1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      idle(3);
      rst_n = 1'b1;
      idle(20);

      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL missing_events got %0d left want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
